// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control slice: FSM encoding,
// register-index width and the packed stage-control bundle.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Bit order is what the bench and debug views assume, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_stall_unit_hazard_detect_comb.sv
// Pure combinational hazard terms: load-use dependency and data-memory stall.
// Shared with the forwarding path, so it carries no state.
module hazard_detect_comb
  import hazard_stall_unit_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ready,
  output logic             load_use,
  output logic             mem_stall
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real destination, so a load "to x0" cannot create a hazard.
  assign rs1_hit   = id_uses_rs1 && (id_rs1 == id_ex_rd);
  assign rs2_hit   = id_uses_rs2 && (id_rs2 == id_ex_rd);
  assign load_use  = id_ex_mem_read && (id_ex_rd != REG_X0) && (rs1_hit || rs2_hit);
  assign mem_stall = ex_mem_mem_req && !dmem_ready;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, branch squashes and dmem
// wait states with a timeout FAULT. Optional counters under HAZARD_STATS_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              ex_mem_mem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_bubble,
  output logic              mem_timeout,
  output logic [1:0]        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
  output logic              fault_seen
`endif
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              timeout_hit;
  ctrl_t             ctrl;

  hazard_detect_comb u_detect (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .ex_mem_mem_req (ex_mem_mem_req),
    .dmem_ready     (dmem_ready),
    .load_use       (load_use),
    .mem_stall      (mem_stall)
  );

  assign timeout_hit = (state == ST_MEM_WAIT) && mem_stall && (wait_cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state       <= ST_FAULT;
            mem_timeout <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_FAULT: ;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Zero-latency enables; EX freeze outranks redirect, which outranks load-use
  // because a squashed ID instruction cannot hazard.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (state == ST_FAULT) begin
      ctrl = CTRL_FREEZE;
    end else if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign dbg_state     = state;
  assign dbg_wait_cnt  = wait_cnt;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      fault_seen   <= 1'b0;
    end else if (state != ST_FAULT) begin
      if (load_use || mem_stall) stall_cycles <= stall_cycles + 32'd1;
      if (ex_branch_taken && !mem_stall) flush_count <= flush_count + 32'd1;
      if (timeout_hit) fault_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: hand-computed control vectors checked
// with immediate assertions, FSM state via the debug outputs.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam int WAIT_W = 5;
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] V_NORM   = 7'b1101010;
  localparam logic [6:0] V_RST    = 7'b0010101;
  localparam logic [6:0] V_LU     = 7'b0001110;
  localparam logic [6:0] V_BR     = 7'b1111110;
  localparam logic [6:0] V_FREEZE = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_ex_mem_read, ex_branch_taken, ex_mem_mem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble;
  logic mem_timeout;
  logic [1:0] dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
  logic fault_seen;
`endif

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  hazard_stall_unit #(.MAX_WAIT(16), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mem_mem_req(ex_mem_mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .fault_seen(fault_seen)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mem_mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard
  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    logic [6:0] e;
    exp_q.push_back(exp);
    got = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble};
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, e);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_fsm(input string tag, input logic [1:0] st, input int cnt, input logic to);
    chk_val({tag, "_state"}, 32'(dbg_state), 32'(st));
    chk_val({tag, "_cnt"}, 32'(dbg_wait_cnt), 32'(cnt));
    chk_val({tag, "_timeout"}, 32'(mem_timeout), 32'(to));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    settle();
    chk_ctrl("reset_outputs", V_RST);
    tick();
    chk_fsm("reset", 2'd0, 0, 1'b0);
    chk_ctrl("reset_outputs_held", V_RST);
    rst = 1'b0;
    settle();
    chk_ctrl("idle", V_NORM);
    tick();

    // load-use on rs1: single bubble, then normal once the load advances
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    settle();
    chk_ctrl("load_use_rs1", V_LU);
    chk_val("load_use_state", 32'(dbg_state), 32'd0);
    tick();
    id_ex_mem_read = 1'b0;
    settle();
    chk_ctrl("after_bubble", V_NORM);
    tick();

    // load to x0 never stalls
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    settle();
    chk_ctrl("x0_no_stall", V_NORM);
    tick();

    // rs2 match only counts when rs2 is read
    id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    settle();
    chk_ctrl("rs2_unused", V_NORM);
    id_uses_rs2 = 1'b1;
    settle();
    chk_ctrl("load_use_rs2", V_LU);

    // branch squashes the dependent ID instruction instead of stalling
    ex_branch_taken = 1'b1;
    settle();
    chk_ctrl("branch_over_load_use", V_BR);
    tick();

    // dmem wait: 3 frozen cycles, pending branch flushes on release
    idle_inputs();
    ex_mem_mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    settle();
    chk_ctrl("wait1", V_FREEZE);
    tick();
    chk_fsm("wait1", 2'd1, 1, 1'b0);
    chk_ctrl("wait2", V_FREEZE);
    tick();
    chk_ctrl("wait3", V_FREEZE);
    tick();
    chk_fsm("wait3", 2'd1, 3, 1'b0);
    dmem_ready = 1'b1;
    settle();
    chk_ctrl("release_branch", V_BR);
    tick();
    chk_fsm("released", 2'd0, 0, 1'b0);

    // release in the first wait cycle
    ex_branch_taken = 1'b0; dmem_ready = 1'b0;
    tick();
    dmem_ready = 1'b1;
    settle();
    chk_ctrl("first_cycle_release", V_NORM);
    tick();
    chk_val("first_release_state", 32'(dbg_state), 32'd0);

    // ready access never enters MEM_WAIT
    tick();
    chk_fsm("ready_access", 2'd0, 0, 1'b0);
    chk_ctrl("ready_access", V_NORM);

    // reset at wait cycle 5
    dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_fsm("pre_reset_wait", 2'd1, 5, 1'b0);
    rst = 1'b1;
    settle();
    chk_ctrl("mid_stall_reset_outputs", V_RST);
    tick();
    chk_fsm("mid_stall_reset", 2'd0, 0, 1'b0);
    rst = 1'b0;
    settle();
    chk_ctrl("stall_after_reset", V_FREEZE);

    // timeout: FAULT after the 16th MEM_WAIT cycle still stalled
    for (int i = 0; i < 16; i++) tick();
    chk_fsm("wait16", 2'd1, 16, 1'b0);
    chk_ctrl("wait16", V_FREEZE);
    tick();
    chk_fsm("fault", 2'd2, 16, 1'b1);
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    settle();
    chk_ctrl("fault_outputs", V_FREEZE);
    tick();
    chk_fsm("fault_absorbing", 2'd2, 16, 1'b1);
`ifdef HAZARD_STATS_EN
    chk_val("fault_seen", 32'(fault_seen), 32'd1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    chk_fsm("fault_cleared", 2'd0, 0, 1'b0);
    chk_ctrl("fault_cleared", V_NORM);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side counterpart of the forwarding logic in the 5-stage RV32I pipeline.
- Forwarding resolves hazards by selecting bypass data. This block resolves the hazards that bypass cannot cover: load-use dependencies, taken-branch redirects and data-memory wait states.
- It drives the stage-register write enables, the flushes and the PC write.
- It sits beside the decode stage and observes ID, ID/EX, EX and EX/MEM control.

Parameters:
- MAX_WAIT, 16: maximum consecutive dmem-not-ready cycles before FAULT is entered.
- WAIT_W, 5: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  rd in the ID/EX register
- id_ex_mem_read  in  1  ID/EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_mem_mem_req  in  1  EX/MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID cleared to NOP
- id_ex_write  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX cleared to bubble
- ex_mem_write  out  1  EX/MEM write enable
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky fault flag

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- State register, 2 bits: RUN=0, MEM_WAIT=1, FAULT=2. Code 3 is illegal and returns to RUN on the next edge.
- During rst (sampled each edge) and the cycle it is asserted:
  - state<=RUN, wait_cnt<=0, mem_timeout<=0.
  - Outputs forced: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
- Hazard terms (combinational):
  - mem_stall = ex_mem_mem_req & ~dmem_ready.
  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
- Outputs are combinational from state plus these terms; there is zero-cycle latency to the enables.
- Default outputs: all writes=1, all flushes/bubble=0.
- Priority, highest first:
  1. State FAULT: all writes=0, mem_wb_bubble=1, flushes=0. Held until reset.
  2. mem_stall (in RUN or MEM_WAIT): pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1. Branch and load-use are ignored this cycle; EX is frozen, so they re-evaluate once the stall releases.
  3. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1. load_use is ignored because the ID instruction is squashed.
  4. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble is inserted; the next cycle id_ex_mem_read=0 naturally.
- Transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt<=1.
  - MEM_WAIT:
    - if ~mem_stall -> RUN, wait_cnt<=0;
    - else if wait_cnt==MAX_WAIT -> FAULT, mem_timeout<=1;
    - else wait_cnt<=wait_cnt+1, saturating (no wrap).
  - FAULT is absorbing until rst.
- Boundary cases:
  - dmem_ready rising in the first wait cycle releases the stall that cycle.
  - A mem request with dmem_ready=1 never enters MEM_WAIT.
  - Reset mid-MEM_WAIT returns to RUN and clears the counter.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, three extra outputs are added:
  - stall_cycles (32b): counts load_use or mem_stall cycles.
  - flush_count (32b): counts ex_branch_taken cycles that are not masked by a stall.
  - fault_seen (1b).
- All three reset to 0, wrap modulo 2^32, and hold in FAULT.
- When undefined, the ports and counters are absent and core behaviour is identical.

Decomposition:
- Shared pipeline package: state encoding constants (RUN/MEM_WAIT/FAULT), the register-index width 5, and the x0 index constant.
- One natural sub-module, hazard_detect_comb: pure combinational load_use/mem_stall generation, reusable by the forwarding path.
- The FSM, counter and output priority stay in the top module.

Test Plan:
- Load-use: load x5 in ID/EX, ID reads rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; normal outputs the next cycle.
- x0 / unused operand: id_ex_rd=0 with rs1=0, or rs2 match with id_uses_rs2=0 -> no stall, all writes=1.
- Branch plus load-use in the same cycle: ex_branch_taken=1, load_use=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
- Memory wait: mem_req=1, dmem_ready low for 3 cycles -> 3 frozen cycles with mem_wb_bubble=1, state MEM_WAIT; release on the 4th cycle; a pending taken branch flushes on the release cycle.
- Timeout: dmem_ready held 0 with MAX_WAIT=16 -> mem_timeout=1 after the 16th wait cycle, all writes=0 thereafter; rst clears to RUN.
- Reset mid-stall: assert rst at wait cycle 5 -> next cycle state RUN, wait_cnt=0, reset output values as listed.
